// File: rtl/routine_tick_gen_pkg.sv
// Shared definitions for the routine tick generator: FSM state encoding and
// default timing constants for a 50 MHz board clock.
package routine_tick_gen_pkg;

  // Routine control states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_STEP_HI = 2'd2
  } state_e;

  // Half-periods in board-clock cycles for the four speed settings
  localparam int unsigned HALF0_DEF = 25_000_000;  // 1 Hz
  localparam int unsigned HALF1_DEF = 12_500_000;  // 2 Hz
  localparam int unsigned HALF2_DEF = 6_250_000;   // 4 Hz
  localparam int unsigned HALF3_DEF = 3_125_000;   // 8 Hz

  // Key must hold a new level this many cycles before it is accepted (10 ms)
  localparam int unsigned DEBOUNCE_DEF = 500_000;

  // Divider counter width, large enough for HALF0_DEF-1
  localparam int unsigned CNT_W_DEF = 25;

endpackage

// File: rtl/routine_tick_gen_key_debouncer.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted release->press (1->0) transition.
// Written for active-low keys; idles released (1) out of reset.
module key_debouncer
  import routine_tick_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_press;
  logic [DB_W-1:0] r_cnt;
  logic            w_differs;
  logic            w_accept;

  // Bring the raw key into the clock domain; idle level is released (1)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // A new level is taken on the Nth consecutive cycle that it differs
  assign w_differs = (r_sync2 != r_level);
  assign w_accept  = w_differs && (r_cnt == DB_LAST);

  // Stability counter, debounced level and registered press pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_press <= w_accept && !r_sync2;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + DB_ONE;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/routine_tick_gen.sv
// Routine clock generator: divides the board clock into a square-wave
// SlowClock at one of four speeds, with pause and single-step control.
// Tick is a same-domain enable marking every SlowClock rising edge.
module routine_tick_gen
  import routine_tick_gen_pkg::*;
#(
  parameter int unsigned HALF0           = HALF0_DEF,
  parameter int unsigned HALF1           = HALF1_DEF,
  parameter int unsigned HALF2           = HALF2_DEF,
  parameter int unsigned HALF3           = HALF3_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Speed,
  input  logic       Pause,
  input  logic       StepKeyN,
  output logic       SlowClock,
  output logic       Tick,
  output logic       Paused
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Terminal count (H-1) for the selected speed
  function automatic logic [CNT_W-1:0] half_last(input logic [1:0] sel);
    case (sel)
      2'd0:    half_last = CNT_W'(HALF0 - 1);
      2'd1:    half_last = CNT_W'(HALF1 - 1);
      2'd2:    half_last = CNT_W'(HALF2 - 1);
      default: half_last = CNT_W'(HALF3 - 1);
    endcase
  endfunction

  logic [1:0]       r_spd_s1;
  logic [1:0]       r_spd_s2;
  logic             r_pau_s1;
  logic             r_pau_s2;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_last;
  logic             r_slow;
  logic             w_slow_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             w_wrap;
  logic             w_press;

  // Switch inputs are asynchronous: two-flop synchronize before use
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_spd_s1 <= 2'd0;
      r_spd_s2 <= 2'd0;
      r_pau_s1 <= 1'b0;
      r_pau_s2 <= 1'b0;
    end else begin
      r_spd_s1 <= Speed;
      r_spd_s2 <= r_spd_s1;
      r_pau_s1 <= Pause;
      r_pau_s2 <= r_pau_s1;
    end
  end

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_key (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_key_n(StepKeyN),
    .o_press(w_press)
  );

  // Speed changes apply at once; >= makes an overshooting counter wrap next cycle
  assign w_last = half_last(r_spd_s2);
  assign w_wrap = (r_cnt >= w_last);

  // Next-state, divider and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_slow_nxt  = r_slow;
    w_tick_nxt  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (r_pau_s2) begin
          w_state_nxt = ST_PAUSE;
          w_cnt_nxt   = '0;
          w_slow_nxt  = 1'b0;
        end else if (w_wrap) begin
          w_cnt_nxt  = '0;
          w_slow_nxt = !r_slow;
          w_tick_nxt = !r_slow;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_PAUSE: begin
        w_cnt_nxt  = '0;
        w_slow_nxt = 1'b0;
        // A press beats a simultaneous pause release
        if (w_press) begin
          w_state_nxt = ST_STEP_HI;
          w_slow_nxt  = 1'b1;
          w_tick_nxt  = 1'b1;
        end else if (!r_pau_s2) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STEP_HI: begin
        // Presses here are dropped; the step always runs a full half-period
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_slow_nxt  = 1'b0;
          w_state_nxt = r_pau_s2 ? ST_PAUSE : ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
        w_slow_nxt  = 1'b0;
      end
    endcase
  end

  // State, divider counter and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_slow  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_slow  <= w_slow_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign SlowClock = r_slow;
  assign Tick      = r_tick;
  assign Paused    = (r_state != ST_RUN);

endmodule
